// File: rtl/fir_pkg.sv
// Shared constants, types, coefficient table and saturation helper for the design_2 FIR.
package fir_pkg;

    localparam int unsigned NTAPS_DEF     = 32;
    localparam int unsigned DATA_W        = 16;
    localparam int unsigned COEF_W        = 16;
    localparam int unsigned ACC_W         = DATA_W + COEF_W + $clog2(NTAPS_DEF);
    localparam int unsigned OUT_SHIFT_DEF = 15;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Symmetric low-pass, h[k] == h[NTAPS-1-k]; DC gain just under unity in Q15.
    localparam coef_t COEFFS [NTAPS_DEF] = '{
        -16'sd40,  16'sd80,   16'sd140,  16'sd220,  16'sd320,  16'sd460,  16'sd620,  16'sd800,
         16'sd1000, 16'sd1220, 16'sd1440, 16'sd1660, 16'sd1860, 16'sd2040, 16'sd2180, 16'sd2260,
         16'sd2260, 16'sd2180, 16'sd2040, 16'sd1860, 16'sd1660, 16'sd1440, 16'sd1220, 16'sd1000,
         16'sd800,  16'sd620,  16'sd460,  16'sd320,  16'sd220,  16'sd140,  16'sd80,  -16'sd40
    };

    localparam acc_t SAT_MAX = acc_t'(signed'(32'h7FFF_FFFF));
    localparam acc_t SAT_MIN = acc_t'(signed'(32'h8000_0000));

    function automatic logic signed [31:0] sat32(input acc_t v);
        if (v > SAT_MAX) begin
            return SAT_MAX[31:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[31:0];
        end
        return v[31:0];
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Combinational dot product of the incoming sample plus delay line against COEFFS.
module fir_mac
    import fir_pkg::*;
(
    input  sample_t sample_i,
    input  sample_t hist_i [NTAPS_DEF-1],
    output acc_t    acc_o
);

    always_comb begin
        acc_o = acc_t'(sample_i) * acc_t'(COEFFS[0]);
        for (int unsigned k = 1; k < NTAPS_DEF; k++) begin
            acc_o = acc_o + acc_t'(hist_i[k-1]) * acc_t'(COEFFS[k]);
        end
    end

endmodule

// File: rtl/design_2_fir.sv
// design_2_fir: AXI4-Stream FIR, one signed 16-bit sample in and one 32-bit result out per beat.
// Optional FIR_CLR_ON_TLAST_EN: zero the delay line after each tlast beat (independent packets).
module design_2_fir
    import fir_pkg::*;
#(
    parameter int unsigned OUT_SHIFT = OUT_SHIFT_DEF
) (
    input  logic        s_aclk_0,
    input  logic        src_rst_0,
    input  logic [31:0] S_AXIS_0_tdata,
    input  logic        S_AXIS_0_tvalid,
    input  logic        S_AXIS_0_tlast,
    output logic        S_AXIS_0_tready,
    output logic [31:0] M_AXIS_0_tdata,
    output logic        M_AXIS_0_tvalid,
    output logic        M_AXIS_0_tlast,
    input  logic        M_AXIS_0_tready
);

    sample_t     x_q [NTAPS_DEF-1];
    sample_t     x_d [NTAPS_DEF-1];
    logic        m_valid_q, m_valid_d;
    logic [31:0] m_data_q,  m_data_d;
    logic        m_last_q,  m_last_d;

    sample_t     sample;
    acc_t        acc;
    acc_t        acc_shifted;
    logic        s_ready;
    logic        in_hs;
    logic        unused_hi;

    assign sample    = sample_t'(S_AXIS_0_tdata[DATA_W-1:0]);
    assign unused_hi = ^S_AXIS_0_tdata[31:DATA_W];

    // Gated by reset so the source sees no ready while the block is held in reset.
    assign s_ready = src_rst_0 && (!m_valid_q || M_AXIS_0_tready);
    assign in_hs   = S_AXIS_0_tvalid && s_ready;

    fir_mac u_mac (
        .sample_i (sample),
        .hist_i   (x_q),
        .acc_o    (acc)
    );

    assign acc_shifted = acc >>> OUT_SHIFT;

    always_comb begin
        x_d       = x_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;

        if (in_hs) begin
            x_d[0] = sample;
            for (int unsigned k = 1; k < NTAPS_DEF - 1; k++) begin
                x_d[k] = x_q[k-1];
            end
            m_valid_d = 1'b1;
            m_data_d  = sat32(acc_shifted);
            m_last_d  = S_AXIS_0_tlast;
`ifdef FIR_CLR_ON_TLAST_EN
            if (S_AXIS_0_tlast) begin
                for (int unsigned k = 0; k < NTAPS_DEF - 1; k++) begin
                    x_d[k] = '0;
                end
            end
`endif
        end else if (M_AXIS_0_tready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge s_aclk_0 or negedge src_rst_0) begin
        if (!src_rst_0) begin
            for (int unsigned k = 0; k < NTAPS_DEF - 1; k++) begin
                x_q[k] <= '0;
            end
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            x_q       <= x_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign S_AXIS_0_tready = s_ready;
    assign M_AXIS_0_tdata  = m_data_q;
    assign M_AXIS_0_tvalid = m_valid_q;
    assign M_AXIS_0_tlast  = m_last_q;

endmodule

// File: tb/tb_design_2_fir.sv
// Scoreboard bench for design_2_fir: history-queue reference model, monitor pops on output handshakes.
module tb_design_2_fir;
    import fir_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;

    int n_cmp = 0;
    int n_err = 0;
    int rdy_mode = 0;

    typedef struct {
        longint data;
        bit     last;
    } exp_t;

    exp_t   exp_q[$];
    longint hist[$];

    always #5 clk = ~clk;

    design_2_fir dut (
        .s_aclk_0        (clk),
        .src_rst_0       (rst_n),
        .S_AXIS_0_tdata  (s_tdata),
        .S_AXIS_0_tvalid (s_tvalid),
        .S_AXIS_0_tlast  (s_tlast),
        .S_AXIS_0_tready (s_tready),
        .M_AXIS_0_tdata  (m_tdata),
        .M_AXIS_0_tvalid (m_tvalid),
        .M_AXIS_0_tlast  (m_tlast),
        .M_AXIS_0_tready (m_tready)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // y = sat32((x[n]*h0 + sum x[n-k]*h[k]) >>> 15), history newest-first.
    task automatic model_accept(input longint s, input bit last);
        longint acc;
        longint y;
        acc = s * longint'(COEFFS[0]);
        for (int k = 1; k < NTAPS_DEF; k++) begin
            if (k - 1 < hist.size()) acc += hist[k-1] * longint'(COEFFS[k]);
        end
        y = acc >>> 15;
        if (y > 64'sd2147483647)  y = 64'sd2147483647;
        if (y < -64'sd2147483648) y = -64'sd2147483648;
        exp_q.push_back('{data: y, last: last});
        hist.push_front(s);
        if (hist.size() > NTAPS_DEF - 1) void'(hist.pop_back());
`ifdef FIR_CLR_ON_TLAST_EN
        if (last) hist.delete();
`endif
    endtask

    task automatic send(input int s, input bit last);
        logic [31:0] r;
        logic [15:0] lo;
        bit          done;
        r    = $urandom;
        lo   = 16'(s);
        done = 1'b0;
        s_tdata  = {r[31:16], lo};
        s_tvalid = 1'b1;
        s_tlast  = last;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (s_tready) begin
                model_accept(longint'($signed(lo)), last);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 0, 1);
        else       check("latency_valid", longint'(m_tvalid), 1);
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", longint'($signed(m_tdata)), e.data);
                    check("tlast", longint'(m_tlast), longint'(e.last));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : main
        exp_t held;
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;

        repeat (4) @(posedge clk);
        #1;
        check("reset_m_tvalid", longint'(m_tvalid), 0);
        check("reset_m_tdata",  longint'(m_tdata), 0);
        check("reset_m_tlast",  longint'(m_tlast), 0);
        check("reset_s_tready", longint'(s_tready), 0);
        rst_n = 1'b1;
        #1;
        check("post_reset_s_tready", longint'(s_tready), 1);
        @(posedge clk);
        #1;

        // Impulse: 32767 then 49 zeros, tlast on the final beat.
        send(32767, 1'b0);
        for (int i = 1; i < 50; i++) send(0, i == 49);
        idle(3);

        // Step/DC at full-scale negative.
        for (int i = 0; i < 64; i++) send(-32768, i == 63);
        idle(3);

        // Held backpressure with a beat pending on the input.
        send(1000, 1'b0);
        send(-2000, 1'b0);
        rdy_mode = 0;
        m_tready = 1'b0;
        held     = exp_q[$];
        s_tvalid = 1'b1;
        s_tdata  = 32'h0000_0BB8;
        s_tlast  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_s_tready", longint'(s_tready), 0);
            check("bp_m_tvalid", longint'(m_tvalid), 1);
            check("bp_tdata",    longint'($signed(m_tdata)), held.data);
            check("bp_tlast",    longint'(m_tlast), longint'(held.last));
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        send(3000, 1'b0);
        send(4000, 1'b1);
        idle(3);

        // Back-to-back impulse packets with no gap.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 40; i++) send((i == 0) ? 32767 : 0, i == 39);
        end
        idle(3);

        // Reset mid-stream after 10 impulse beats.
        for (int i = 0; i < 10; i++) send((i == 0) ? 32767 : 0, 1'b0);
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        #1;
        check("midrst_m_tvalid", longint'(m_tvalid), 0);
        check("midrst_m_tdata",  longint'(m_tdata), 0);
        check("midrst_s_tready", longint'(s_tready), 0);
        exp_q.delete();
        hist.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 40; i++) send((i == 0) ? 32767 : 0, i == 39);
        idle(3);

        // Random samples, gaps, tlast and sink backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 7) == 0);
        end
        rdy_mode = 0;
        m_tready = 1'b1;
        idle(6);
        check("queue_drained", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
